gpio_loopback_sequencer: RTL
============================

// Module: gpio_loopback_sequencer
// PURPOSE
//   Self-checking test sequencer for the 17-bit GPIO loopback path (16 data bits + bit-16 parity).
//   Drives GPIO_OUT vectors and schedules the loopback's `error` (parity-flip) injection.
//   Samples GPIO_IN after the loopback's register latency; counts data and parity failures.
//   Sits between the test-control registers and the loopback model in the ahb_gpio unit bench.
// PARAMETERS
//   LATENCY    1  cycles from GPIO_OUT change to valid GPIO_IN (loopback register depth); >=1
//   CNT_W      8  width of vector count, injection index and error counters
//   PARITY_ODD 0  0: GPIO_OUT[16] = ^data (even parity); 1: GPIO_OUT[16] = ~^data (odd parity)
// PORTS
//   clk             in   1      system clock, rising edge
//   reset_n         in   1      asynchronous, active-low reset
//   start           in   1      1-cycle run request; sampled only in IDLE
//   num_vec         in   CNT_W  vectors per run; latched on accepted start
//   inj_en          in   1      enable error injection for this run; latched on start
//   inj_idx         in   CNT_W  vector index that receives the injected error; latched on start
//   GPIO_IN         in   17     loopback return {parity, data}
//   GPIO_OUT        out  17     driven vector {parity, data}
//   error           out  1      to loopback: invert returned bit 16
//   busy            out  1      run in progress
//   done            out  1      run finished; held until next accepted start
//   pass            out  1      valid with done: 1 iff fail_cnt==0
//   fail_cnt        out  CNT_W  failing vectors this run, saturating at all-ones
//   par_fail_cnt    out  CNT_W  vectors with a parity mismatch only, saturating
//   first_fail_idx  out  CNT_W  index of first failing vector; all-ones if none
// BEHAVIOUR
//   Reset values: GPIO_OUT=0, error=0, busy=0, done=0, pass=0, counters=0, first_fail_idx='1, FSM=IDLE.
//   FSM: IDLE -> DRIVE -> WAIT -> CHECK -> (DRIVE | DONE) -> IDLE.
//   IDLE:  start=1 latches the inputs, clears counters/done/pass, first_fail_idx='1, vec_idx=0.
//          Loads pattern seed; busy=1 from next cycle.
//          num_vec==0 -> goes straight to DONE (pass=1).
//   DRIVE (1 cyc): registers GPIO_OUT <= {par(pat), pat}; error <= inj_en && (vec_idx==inj_idx).
//   WAIT (LATENCY cyc): GPIO_OUT and error held stable.
//   CHECK (1 cyc): GPIO_IN sampled; GPIO_OUT and error still held.
//     data_bad = GPIO_IN[15:0] != pat
//     par_bad  = GPIO_IN[16] != par(GPIO_IN[15:0])
//     Vector fails if data_bad|par_bad: fail_cnt++, par_fail_cnt++ if par_bad&&!data_bad.
//     first_fail_idx set on first failure.
//     Then vec_idx++, pattern advances; vec_idx==num_vec-1 -> DONE else DRIVE.
//   Per vector: LATENCY+2 cycles (3 at default).
//   DONE (1 cyc): error<=0, busy<=0, done<=1, pass<=(fail_cnt==0); -> IDLE.
//     GPIO_OUT keeps last vector.
//   start while busy: ignored. start in the DONE cycle: ignored (accepted only in IDLE).
//   Counters saturate at all-ones, never wrap. vec_idx is CNT_W wide; num_vec=all-ones runs 2^CNT_W-1 vectors.
//   inj_idx >= num_vec: no injection occurs.
//   Reset mid-run: immediate return to reset values; results discarded; no done pulse.
//   Default pattern: walking one, seed 16'h0001, rotate left 1 per vector (bit15 -> bit0).
// CONFIGURATION
//   LB_LFSR_EN defined:
//     pattern = 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1, one shift per vector.
//     next = {pat[14:0], pat[15]^pat[13]^pat[12]^pat[10]}.
//   LB_LFSR_EN undefined: walking-one pattern above; LFSR logic absent.
// TESTING
//   Basic: num_vec=4, inj_en=0 -> GPIO_OUT data 0001,0002,0004,0008 (par=1 each).
//     done after 12 cycles, pass=1, fail_cnt=0, first_fail_idx=FF.
//   Injection: num_vec=4, inj_en=1, inj_idx=2 -> error high only during vector 2.
//     fail_cnt=1, par_fail_cnt=1, first_fail_idx=2, pass=0.
//   Stuck bit: GPIO_IN[3] forced 0, num_vec=16 -> fail_cnt=1 (data 0008 only), par_fail_cnt=0, first_fail_idx=3.
//   Zero/ignored start: num_vec=0 -> done next cycle, pass=1.
//     start pulsed mid-run -> run length unchanged.
//   Reset mid-run: reset_n low in WAIT of vector 1 -> all outputs reset values.
//     A new start then runs from vector 0.
//   LB_LFSR_EN: num_vec=2 -> data ACE1 then 59C3 (first LFSR shift from ACE1).
//     pass=1.

Source files
------------

// File: rtl/gpio_loopback_sequencer.sv
// Drives test vectors onto the 17-bit GPIO loopback, schedules parity-flip injection and scores returns.
// Optional LB_LFSR_EN: LFSR pattern source instead of the walking-one pattern.
module gpio_loopback_sequencer #(
    parameter int LATENCY    = 1,
    parameter int CNT_W      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             inj_en,
    input  logic [CNT_W-1:0] inj_idx,
    input  logic [16:0]      GPIO_IN,
    output logic [16:0]      GPIO_OUT,
    output logic             error,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] par_fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

`ifdef LB_LFSR_EN
    localparam logic [15:0] SEED = 16'hACE1;
    function automatic logic [15:0] next_pat(input logic [15:0] p);
        return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    endfunction
`else
    localparam logic [15:0] SEED = 16'h0001;
    function automatic logic [15:0] next_pat(input logic [15:0] p);
        return {p[14:0], p[15]};
    endfunction
`endif

    function automatic logic par(input logic [15:0] d);
        return PARITY_ODD ? ~^d : ^d;
    endfunction

    state_t           state_q, state_d;
    logic [16:0]      gpio_q, gpio_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] pfail_q, pfail_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0] nvec_q, nvec_d;
    logic             inj_en_q, inj_en_d;
    logic [CNT_W-1:0] inj_idx_q, inj_idx_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [15:0]      pat_q, pat_d;
    logic [LAT_W-1:0] wait_q, wait_d;
    logic             data_bad, par_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            gpio_q    <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            pfail_q   <= '0;
            first_q   <= '1;
            nvec_q    <= '0;
            inj_en_q  <= 1'b0;
            inj_idx_q <= '0;
            vec_idx_q <= '0;
            pat_q     <= SEED;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            gpio_q    <= gpio_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            pfail_q   <= pfail_d;
            first_q   <= first_d;
            nvec_q    <= nvec_d;
            inj_en_q  <= inj_en_d;
            inj_idx_q <= inj_idx_d;
            vec_idx_q <= vec_idx_d;
            pat_q     <= pat_d;
            wait_q    <= wait_d;
        end
    end

    assign data_bad = (GPIO_IN[15:0] != pat_q);
    assign par_bad  = (GPIO_IN[16] != par(GPIO_IN[15:0]));

    always_comb begin
        state_d   = state_q;
        gpio_d    = gpio_q;
        error_d   = error_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        pfail_d   = pfail_q;
        first_d   = first_q;
        nvec_d    = nvec_q;
        inj_en_d  = inj_en_q;
        inj_idx_d = inj_idx_q;
        vec_idx_d = vec_idx_q;
        pat_d     = pat_q;
        wait_d    = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nvec_d    = num_vec;
                    inj_en_d  = inj_en;
                    inj_idx_d = inj_idx;
                    fail_d    = '0;
                    pfail_d   = '0;
                    first_d   = '1;
                    vec_idx_d = '0;
                    pat_d     = SEED;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = (num_vec == '0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                gpio_d  = {par(pat_q), pat_q};
                error_d = inj_en_q && (vec_idx_q == inj_idx_q);
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == LAT_W'(LATENCY - 1)) state_d = S_CHECK;
                else                               wait_d  = wait_q + LAT_W'(1);
            end
            S_CHECK: begin
                // fail_q==0 doubles as "no failure seen yet" since the counter saturates, never wraps
                if (data_bad || par_bad) begin
                    if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
                    if (par_bad && !data_bad && pfail_q != CNT_MAX) pfail_d = pfail_q + CNT_W'(1);
                    if (fail_q == '0) first_d = vec_idx_q;
                end
                vec_idx_d = vec_idx_q + CNT_W'(1);
                pat_d     = next_pat(pat_q);
                state_d   = (vec_idx_q == nvec_q - CNT_W'(1)) ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                error_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign GPIO_OUT       = gpio_q;
    assign error          = error_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_cnt       = fail_q;
    assign par_fail_cnt   = pfail_q;
    assign first_fail_idx = first_q;

endmodule
